master_serializer: RTL and testbench
====================================

Name: master_serializer

Overview:
- Upstream master-side port of the serial bus; feeds the arbiter's m1 inputs.
- Accepts one parallel write request (address plus data) from the local master logic.
- Waits for the arbiter to report the bus free, then serialises the address and data MSB-first onto m1_address and m1_data.
- Frames the transfer with m1_valid and a one-cycle m1_address_valid start strobe.

Parameters:
- ADDR_WIDTH, 16, serial address bits per frame; top 2 bits select the slave.
- DATA_WIDTH, 8, serial data bits per frame.

Ports:
- clk  input  1  bus clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  local master presents a request.
- req_addr  input  ADDR_WIDTH  request address.
- req_data  input  DATA_WIDTH  request write data.
- req_ready  output  1  block can accept a request; high only in IDLE.
- m1_ready  input  1  arbiter reports the bus free and able to take a new frame.
- m1_address  output  1  serial address bit, MSB first.
- m1_data  output  1  serial data bit, MSB first.
- m1_valid  output  1  high for every cycle of an address or data bit.
- m1_address_valid  output  1  one-cycle strobe on the first address bit.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - m1_address, m1_data, m1_valid, m1_address_valid and busy all go to 0.
  - req_ready goes to 1.
  - Shift registers and bit counter clear to 0.
- States: IDLE, WAIT_BUS, ADDR, DATA, GAP. All outputs are registered.
- IDLE:
  - req_ready=1.
  - When req_valid=1 at a clock edge, latch req_addr and req_data, then go to WAIT_BUS.
- WAIT_BUS:
  - req_ready=0 and all m1_* outputs are 0.
  - When m1_ready=1 at a clock edge, go to ADDR.
  - No timeout; the block waits indefinitely.
- ADDR (exactly ADDR_WIDTH cycles):
  - m1_valid=1.
  - m1_address = addr[ADDR_WIDTH-1-k] on cycle k.
  - m1_address_valid=1 on cycle 0 only.
  - m1_data=0.
- DATA (exactly DATA_WIDTH cycles):
  - m1_valid=1.
  - m1_data = data[DATA_WIDTH-1-k] on cycle k.
  - m1_address=0.
- GAP (1 cycle):
  - All m1_* outputs are 0.
  - Then return to IDLE; req_ready rises the following cycle.
- Latency and throughput:
  - Request accept edge to first address bit: 2 cycles when m1_ready is already high.
  - Frame length is ADDR_WIDTH+DATA_WIDTH cycles with m1_valid held continuously.
  - Minimum spacing between frames is frame length + 3 cycles.
- Bit counter:
  - Width is $clog2(max(ADDR_WIDTH,DATA_WIDTH)).
  - Counts 0..WIDTH-1 in the current phase and clears on each phase change.
  - No wrap-around within a phase.
- Boundary conditions:
  - m1_ready falling during ADDR or DATA is ignored; a started frame always completes.
  - req_valid held high through a frame is not re-accepted until IDLE.
  - req_addr and req_data changing after acceptance have no effect.
  - Reset asserted mid-frame: outputs drop to 0 in the same instant (asynchronously); the frame is truncated with no recovery.
  - After reset deasserts, the block is in IDLE and the next req_valid starts a fresh frame.

Decomposition:
- Shared package bus_pkg holds:
  - ADDR_WIDTH, DATA_WIDTH, SLAVE_SEL_BITS=2.
  - State encoding (IDLE=0, WAIT_BUS=1, ADDR=2, DATA=3, GAP=4).
  - These are reused by the arbiter and the slave-side deserialiser.
- One sub-module, piso_shift:
  - Parameterised parallel-in serial-out shifter with load and shift enables, MSB first.
  - Instantiated twice, once for address and once for data.

Test Plan:
- Basic frame: after reset, with m1_ready=1, send req_addr=16'hA5C3, req_data=8'h5A.
  - m1_address_valid pulses once.
  - m1_address sequence is 1010010111000011.
  - m1_data sequence is 01011010.
  - m1_valid is high for 24 consecutive cycles.
  - Then GAP, with req_ready=1 two edges after m1_valid falls.
- Bus busy: hold m1_ready=0 for 10 cycles after the request.
  - Block stays in WAIT_BUS with m1_valid=0.
  - First address bit appears 1 cycle after m1_ready rises.
- m1_ready dropped mid-frame: deassert m1_ready during the 5th address bit.
  - Frame completes unchanged: 24 valid cycles with the correct bits.
- Reset mid-frame: assert reset during the 3rd data bit of addr=16'hFFFF, data=8'hFF.
  - All m1_* outputs are 0 immediately, before the next clock edge.
  - After release, a new request addr=16'h0001, data=8'h80 transfers correctly.
- Back-to-back requests: hold req_valid=1 with two request values.
  - The second request is accepted only when req_ready=1.
  - Spacing between the two m1_address_valid pulses is exactly 27 cycles.
- Request-field stability: change req_addr and req_data every cycle after acceptance.
  - Serialised bits match the values latched at the accept edge.

Source files
------------

// File: rtl/master_serializer_pkg.sv
// Shared bus definitions: frame widths and the serializer state encoding.
// The arbiter and the slave-side deserialiser import the same package.
package bus_pkg;
  localparam int ADDR_WIDTH     = 16;
  localparam int DATA_WIDTH     = 8;
  localparam int SLAVE_SEL_BITS = 2;
  localparam int CNT_W = $clog2(ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BUS = 3'd1,
    ADDR     = 3'd2,
    DATA     = 3'd3,
    GAP      = 3'd4
  } state_e;
endpackage

// File: rtl/master_serializer_if.sv
// Request and serial-bus signals of the master serializer.
// master = serializer view, slave = local master logic / arbiter view.
interface master_serializer_if;
  import bus_pkg::*;
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  req_ready;
  logic                  m1_ready;
  logic                  m1_address;
  logic                  m1_data;
  logic                  m1_valid;
  logic                  m1_address_valid;
  logic                  busy;

  modport master (
    input  req_valid, req_addr, req_data, m1_ready,
    output req_ready, m1_address, m1_data, m1_valid, m1_address_valid, busy
  );
  modport slave (
    output req_valid, req_addr, req_data, m1_ready,
    input  req_ready, m1_address, m1_data, m1_valid, m1_address_valid, busy
  );
endinterface

// File: rtl/master_serializer_piso_shift.sv
// Parallel-in serial-out shifter, MSB first; load wins over shift.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] par_i,
  output logic         ser_o
);
  logic [W-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sr_q <= '0;
    else if (load_i)  sr_q <= par_i;
    else if (shift_i) sr_q <= {sr_q[W-2:0], 1'b0};
  end

  assign ser_o = sr_q[W-1];
endmodule

// File: rtl/master_serializer.sv
// Serialises one latched address/data write request onto the m1 bus.
// m1 outputs are registered from the current state, so each bit trails its state cycle by one edge.
module master_serializer
  import bus_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  master_serializer_if.master bus
);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_ready_q, busy_q;
  logic             m1_address_q, m1_data_q, m1_valid_q, m1_address_valid_q;
  logic             load, addr_shift, data_shift, addr_bit, data_bit;

  assign load       = (state_q == IDLE) && bus.req_valid;
  assign addr_shift = (state_q == ADDR);
  assign data_shift = (state_q == DATA);

  piso_shift #(.W(ADDR_WIDTH)) u_addr_sr (
    .clk(clk), .rst_n(reset), .load_i(load), .shift_i(addr_shift),
    .par_i(bus.req_addr), .ser_o(addr_bit)
  );

  piso_shift #(.W(DATA_WIDTH)) u_data_sr (
    .clk(clk), .rst_n(reset), .load_i(load), .shift_i(data_shift),
    .par_i(bus.req_data), .ser_o(data_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      req_ready_q        <= 1'b1;
      busy_q             <= 1'b0;
      m1_address_q       <= 1'b0;
      m1_data_q          <= 1'b0;
      m1_valid_q         <= 1'b0;
      m1_address_valid_q <= 1'b0;
    end else begin
      m1_address_q       <= 1'b0;
      m1_data_q          <= 1'b0;
      m1_valid_q         <= 1'b0;
      m1_address_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.req_valid) begin
          state_q     <= WAIT_BUS;
          req_ready_q <= 1'b0;
          busy_q      <= 1'b1;
        end
        WAIT_BUS: if (bus.m1_ready) begin
          state_q <= ADDR;
          cnt_q   <= '0;
        end
        // m1_ready is deliberately ignored once a frame has started.
        ADDR: begin
          m1_valid_q         <= 1'b1;
          m1_address_q       <= addr_bit;
          m1_address_valid_q <= (cnt_q == '0);
          if (cnt_q == ADDR_LAST) begin
            state_q <= DATA;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          m1_valid_q <= 1'b1;
          m1_data_q  <= data_bit;
          if (cnt_q == DATA_LAST) begin
            state_q <= GAP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready        = req_ready_q;
  assign bus.busy             = busy_q;
  assign bus.m1_address       = m1_address_q;
  assign bus.m1_data          = m1_data_q;
  assign bus.m1_valid         = m1_valid_q;
  assign bus.m1_address_valid = m1_address_valid_q;
endmodule

// File: tb/tb_master_serializer.sv
// Directed bench for master_serializer: the driver pushes accepted requests into a
// scoreboard queue; a negedge monitor reassembles each serial frame and compares.
module tb_master_serializer;
  import bus_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;

  logic [23:0] exp_q[$];
  int          pulse_q[$];

  master_serializer_if bus ();
  master_serializer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: assemble frames on the falling edge.
  int          bc = 0;
  int          av_bad = 0;
  int          stray = 0;
  logic [15:0] a_acc;
  logic [7:0]  d_acc;
  logic [23:0] e;
  always @(negedge clk) begin
    if (!reset) begin
      bc = 0; av_bad = 0; stray = 0;
    end else if (bus.m1_valid) begin
      if (bus.m1_address_valid !== (bc == 0)) av_bad++;
      if (bus.m1_address_valid) pulse_q.push_back(cyc);
      if (bc < 16) begin
        a_acc = {a_acc[14:0], bus.m1_address};
        if (bus.m1_data) stray++;
      end else begin
        d_acc = {d_acc[6:0], bus.m1_data};
        if (bus.m1_address) stray++;
      end
      bc++;
      if (bc == 24) begin
        if (exp_q.size() == 0) begin
          check("frame_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("frame_addr", {16'h0, a_acc}, {16'h0, e[23:8]});
          check("frame_data", {24'h0, d_acc}, {24'h0, e[7:0]});
        end
        check("frame_av_strobe", av_bad, 0);
        check("frame_stray_bits", stray, 0);
        bc = 0; av_bad = 0; stray = 0;
      end
    end else if (bc != 0) begin
      check("frame_truncated", bc, 24);
      bc = 0; av_bad = 0; stray = 0;
    end
  end

  task automatic send(input logic [15:0] a, input logic [7:0] d, input bit hold, input bit push);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_data = d;
    while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.req_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    if (push) exp_q.push_back({a, d});
    #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_av();
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.m1_address_valid && n < 100);
    if (!bus.m1_address_valid) check("wait_av_timeout", 0, 1);
  endtask

  task automatic wait_fall();
    int n = 0;
    do begin @(negedge clk); n++; end while (bus.m1_valid && n < 100);
    if (bus.m1_valid) check("wait_fall_timeout", 1, 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin @(negedge clk); n++; end while ((exp_q.size() != 0 || bus.busy) && n < 400);
    check("drain", exp_q.size() + int'(bus.busy), 0);
  endtask

  initial begin
    int bad;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_data = '0; bus.m1_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_m1", {bus.m1_valid, bus.m1_address_valid, bus.m1_address, bus.m1_data}, 0);
    reset = 1'b1;

    // Basic frame plus first-bit latency
    send(16'hA5C3, 8'h5A, 0, 1);
    @(negedge clk); check("lat_e0_valid", bus.m1_valid, 0);
    check("lat_e0_busy", bus.busy, 1);
    check("lat_e0_ready", bus.req_ready, 0);
    @(negedge clk); check("lat_e1_valid", bus.m1_valid, 0);
    @(negedge clk); check("lat_e2_valid_av", {bus.m1_valid, bus.m1_address_valid}, 2'b11);
    wait_fall();
    @(posedge clk); @(posedge clk); #1;
    check("gap_req_ready", bus.req_ready, 1);
    check("gap_busy", bus.busy, 0);

    // Bus busy: held in WAIT_BUS
    bus.m1_ready = 1'b0;
    send(16'h1234, 8'hC3, 0, 1);
    bad = 0;
    repeat (10) begin @(negedge clk); if (bus.m1_valid) bad++; end
    check("wait_bus_no_valid", bad, 0);
    check("wait_bus_busy", bus.busy, 1);
    bus.m1_ready = 1'b1;
    @(negedge clk); check("wait_rel_e0", bus.m1_valid, 0);
    @(negedge clk); check("wait_rel_e1_av", {bus.m1_valid, bus.m1_address_valid}, 2'b11);
    wait_drain();

    // m1_ready dropped during 5th address bit
    send(16'hF00F, 8'h81, 0, 1);
    wait_av();
    repeat (4) @(negedge clk);
    bus.m1_ready = 1'b0;
    wait_fall();
    bus.m1_ready = 1'b1;
    wait_drain();

    // Reset mid-frame at 3rd data bit
    send(16'hFFFF, 8'hFF, 0, 0);
    wait_av();
    repeat (18) @(negedge clk);
    check("pre_rst_data", {bus.m1_valid, bus.m1_data}, 2'b11);
    reset = 1'b0;
    #1;
    check("async_rst_m1", {bus.m1_valid, bus.m1_address_valid, bus.m1_address, bus.m1_data}, 0);
    check("async_rst_ready_busy", {bus.req_ready, bus.busy}, 2'b10);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send(16'h0001, 8'h80, 0, 1);
    wait_drain();

    // Back-to-back with req_valid held
    pulse_q.delete();
    send(16'hBEEF, 8'h3C, 1, 1);
    send(16'h0F0F, 8'hE7, 0, 1);
    wait_drain();
    if (pulse_q.size() >= 2) check("b2b_spacing", pulse_q[1] - pulse_q[0], 27);
    else check("b2b_pulses", pulse_q.size(), 2);

    // Request fields changing after acceptance
    send(16'h6C39, 8'hA4, 0, 1);
    repeat (30) begin
      @(negedge clk);
      bus.req_addr = 16'($urandom); bus.req_data = 8'($urandom);
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
